keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// keypad_scan_ctrl
//
// Scans a ROWS x COLS matrix keypad. A one-hot strobe walks across the
// columns. The synchronised row lines are sampled, and presses and releases
// are debounced. Each confirmed press produces one encoded key event on a
// valid/ready handshake toward the multiplier front end.
//
// Ports:
//   slow_clk     scan clock. All state updates on the rising edge.
//   rst          asynchronous, active-low reset.
//   row_in       row sense lines (already synchronised, active-high).
//   col_drive    one-hot column strobe. Column 0 after reset.
//   key_code     col_idx*ROWS + row_idx of the confirmed key.
//   key_multi    more than one row bit was set when the press confirmed.
//   key_valid    an event is waiting for the consumer.
//   key_ready    the consumer accepts the event.
//   key_pressed  a confirmed key is currently held.
//   overflow     one-cycle pulse. An event was dropped because the previous
//                event was still pending.
//
// Optional feature (compile-time macro KEY_REPEAT_EN):
//   Auto-repeat while a key is held. The first re-emit comes REPEAT_DELAY
//   cycles after entry into HELD. Later re-emits follow every REPEAT_PERIOD
//   cycles. Without the macro, each press emits exactly one event and the
//   REPEAT_* parameters do not exist.
// -----------------------------------------------------------------------------
module keypad_scan_ctrl #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
`ifdef KEY_REPEAT_EN
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8,
`endif
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         slow_clk,
  input  logic                         rst,
  input  logic [ROWS-1:0]              row_in,
  output logic [COLS-1:0]              col_drive,
  output logic [$clog2(ROWS*COLS)-1:0] key_code,
  output logic                         key_multi,
  output logic                         key_valid,
  input  logic                         key_ready,
  output logic                         key_pressed,
  output logic                         overflow
);

  localparam int CODE_W = $clog2(ROWS * COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t            state_q, state_d;
  logic [COLS-1:0]   col_drive_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [COL_W-1:0]  cand_col_q, cand_col_d;
  logic [ROWS-1:0]   cand_row_q, cand_row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              advance;
  logic              confirm;
  logic              emit;
  logic              load;
  logic [ROW_W-1:0]  row_idx;
  logic [CODE_W-1:0] ev_code;
  logic              ev_multi;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    col_drive_d = col_drive;
    col_idx_d  = col_idx_q;
    cand_col_d = cand_col_q;
    cand_row_d = cand_row_q;
    cnt_d      = cnt_q;
    advance    = 1'b0;
    confirm    = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (row_in == '0) begin
          advance = 1'b1;
        end else begin
          cand_col_d = col_idx_q;
          cand_row_d = row_in;
          cnt_d      = '0;
          state_d    = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (row_in == cand_row_q) begin
          if (cnt_q == CNT_LAST) begin
            confirm = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          advance = 1'b1;
          state_d = SCAN;
        end
      end
      HELD: begin
        // Only an all-zero run releases the key. A different nonzero pattern
        // is treated as the same held key.
        if (row_in == '0) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            advance = 1'b1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase

    if (advance) begin
      col_drive_d = {col_drive[COLS-2:0], col_drive[COLS-1]};
      col_idx_d   = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from values taken before the edge.
  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SCAN;
      col_drive  <= COLS'(1);
      col_idx_q  <= '0;
      cand_col_q <= '0;
      cand_row_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_drive  <= col_drive_d;
      col_idx_q  <= col_idx_d;
      cand_col_q <= cand_col_d;
      cand_row_q <= cand_row_d;
      cnt_q      <= cnt_d;
    end
  end

  assign key_pressed = (state_q == HELD);

  // The event encoding uses the lowest set row of the captured pattern.
  always_comb begin
    row_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (cand_row_q[i]) row_idx = ROW_W'(i);
    end
  end

  assign ev_code  = CODE_W'(cand_col_q) * CODE_W'(ROWS) + CODE_W'(row_idx);
  assign ev_multi = |(cand_row_q & (cand_row_q - ROWS'(1)));

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
  logic             row_nz_q;
  logic             rep_fire;

  // The counter idles at zero outside HELD, so it starts from zero on entry.
  // The first interval is REPEAT_DELAY. Later intervals are REPEAT_PERIOD.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (state_q != HELD || (row_nz_q && row_in == '0)) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (rep_cnt_q == (rep_first_q ? DELAY_LAST : PERIOD_LAST)) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else begin
      rep_cnt_d = rep_cnt_q + REP_W'(1);
    end
  end

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
      row_nz_q    <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      row_nz_q    <= |row_in;
    end
  end

  assign emit = confirm | rep_fire;
`else
  assign emit = confirm;
`endif

  // An event loads into an empty slot, or into the slot being accepted this
  // cycle. Otherwise it is dropped and the pending event stays untouched.
  assign load = emit & (~key_valid | key_ready);

  always_ff @(posedge slow_clk or negedge rst) begin
    if (!rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      key_multi <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= emit & ~load;
      if (load) begin
        key_valid <= 1'b1;
        key_code  <= ev_code;
        key_multi <= ev_multi;
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_ctrl
//
// Drives directed keypad scenarios followed by randomised press/bounce
// traffic. Every cycle, a behavioural model of the scanner is compared with
// the DUT outputs. Hand-computed expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_keypad_scan_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int DB     = 4;
  localparam int CODE_W = $clog2(ROWS * COLS);

  logic              slow_clk = 1'b0;
  logic              rst      = 1'b1;
  logic [ROWS-1:0]   row_in   = '0;
  logic              key_ready = 1'b0;
  logic [COLS-1:0]   col_drive;
  logic [CODE_W-1:0] key_code;
  logic              key_multi;
  logic              key_valid;
  logic              key_pressed;
  logic              overflow;

  keypad_scan_ctrl #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .slow_clk    (slow_clk),
    .rst         (rst),
    .row_in      (row_in),
    .col_drive   (col_drive),
    .key_code    (key_code),
    .key_multi   (key_multi),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_pressed (key_pressed),
    .overflow    (overflow)
  );

  always #5 slow_clk = ~slow_clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. The scan column is a plain integer. A press is tracked
  // as a candidate pattern plus the count of identical samples seen after it.
  // A held key is tracked with a run length of zero samples. The pending
  // event is a queue of at most one entry.
  // ---------------------------------------------------------------------------
  typedef struct {
    int code;
    bit multi;
  } ev_t;

  ev_t             pend[$];
  int              m_col   = 0;
  bit              m_track = 1'b0;
  logic [ROWS-1:0] m_cand  = '0;
  int              m_ccol  = 0;
  int              m_run   = 0;
  bit              m_held  = 1'b0;
  int              m_zrun  = 0;
  bit              m_ovf   = 1'b0;

  function automatic int low_bit(input logic [ROWS-1:0] v);
    for (int i = 0; i < ROWS; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    pend.delete();
    m_col = 0; m_track = 1'b0; m_cand = '0; m_ccol = 0;
    m_run = 0; m_held = 1'b0; m_zrun = 0; m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic [ROWS-1:0] r, input logic rdy);
    bit  accept;
    bit  emit;
    ev_t ev;
    accept = (pend.size() != 0) && rdy;
    emit   = 1'b0;
    if (m_held) begin
      if (r == 0) begin
        m_zrun++;
        if (m_zrun == DB) begin
          m_held = 1'b0;
          m_col  = (m_col + 1) % COLS;
        end
      end else begin
        m_zrun = 0;
      end
    end else if (m_track) begin
      if (r == m_cand) begin
        m_run++;
        if (m_run == DB) begin
          emit    = 1'b1;
          m_track = 1'b0;
          m_held  = 1'b1;
          m_zrun  = 0;
        end
      end else begin
        m_track = 1'b0;
        m_col   = (m_col + 1) % COLS;
      end
    end else if (r != 0) begin
      m_track = 1'b1;
      m_cand  = r;
      m_ccol  = m_col;
      m_run   = 0;
    end else begin
      m_col = (m_col + 1) % COLS;
    end

    if (accept) void'(pend.pop_front());
    m_ovf = 1'b0;
    if (emit) begin
      ev.code  = m_ccol * ROWS + low_bit(m_cand);
      ev.multi = ($countones(m_cand) > 1);
      if (pend.size() == 0) pend.push_back(ev);
      else m_ovf = 1'b1;
    end
  endtask

  always @(posedge slow_clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step(row_in, key_ready);
  end

  // One compare process, sampling at the falling edge.
  always @(negedge slow_clk) begin
    check("col_drive", col_drive, 32'(1) << m_col);
    check("key_valid", key_valid, pend.size() != 0);
    if (pend.size() != 0) begin
      check("key_code", key_code, pend[0].code);
      check("key_multi", key_multi, pend[0].multi);
    end
    check("key_pressed", key_pressed, m_held);
    check("overflow", overflow, m_ovf);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic [ROWS-1:0] r, input logic rdy);
    row_in    = r;
    key_ready = rdy;
    @(posedge slow_clk);
    #1;
  endtask

  task automatic goto_col(input int c, input logic rdy);
    logic [COLS-1:0] target;
    int n;
    target = COLS'(1) << c;
    n = 0;
    while (col_drive != target && n < 2 * COLS) begin
      step('0, rdy);
      n++;
    end
    check("goto_col", col_drive, target);
  endtask

  task automatic do_reset();
    row_in = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_col_drive", col_drive, 1);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_multi", key_multi, 0);
    check("rst_key_pressed", key_pressed, 0);
    check("rst_overflow", overflow, 0);
    @(posedge slow_clk);
    #1 rst = 1'b1;
  endtask

  int              lat;
  int              seen_code;
  int              seen_multi;
  int              seen_pressed;
  int              ovf_cnt;
  int              any_valid;
  logic [COLS-1:0] c0;
  logic [COLS-1:0] c_next;
  logic [ROWS-1:0] v;

  initial begin
    // Idle scan: the strobe walks 0010, 0100, 1000, 0001, ...
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step('0, 1'b1);
      check("idle_col", col_drive, 32'(1) << ((i + 1) % COLS));
      check("idle_valid", key_valid, 0);
    end

    // Press row 1 on column 2. Valid after 5 samples, code 9.
    goto_col(2, 1'b1);
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      step(4'b0010, 1'b1);
      if (key_valid && lat == 0) begin
        lat          = k;
        seen_code    = key_code;
        seen_multi   = key_multi;
        seen_pressed = key_pressed;
      end
    end
    check("press_latency", lat, 5);
    check("press_code", seen_code, 9);
    check("press_multi", seen_multi, 0);
    check("press_pressed", seen_pressed, 1);
    repeat (3) step('0, 1'b1);
    check("release_still_held", key_pressed, 1);
    step('0, 1'b1);
    check("release_pressed", key_pressed, 0);
    check("release_col", col_drive, 4'b1000);

    // Glitch during debounce: no event, strobe advances.
    c0 = col_drive;
    c_next = {c0[COLS-2:0], c0[COLS-1]};
    step(4'b0001, 1'b1);
    check("glitch_hold_col", col_drive, c0);
    step('0, 1'b1);
    check("glitch_adv_col", col_drive, c_next);
    any_valid = 0;
    repeat (6) begin
      step('0, 1'b1);
      any_valid |= key_valid;
    end
    check("glitch_no_event", any_valid, 0);

    // Consumer stalled: code 0 pending, code 15 dropped with one overflow.
    goto_col(0, 1'b0);
    repeat (6) step(4'b0001, 1'b0);
    check("stall_valid", key_valid, 1);
    check("stall_code0", key_code, 0);
    repeat (5) step('0, 1'b0);
    goto_col(3, 1'b0);
    ovf_cnt = 0;
    repeat (7) begin
      step(4'b1000, 1'b0);
      ovf_cnt += int'(overflow);
    end
    check("stall_ovf_pulses", ovf_cnt, 1);
    check("stall_code_kept", key_code, 0);
    repeat (5) step('0, 1'b0);
    check("stall_valid_kept", key_valid, 1);
    step('0, 1'b1);
    check("stall_accepted", key_valid, 0);

    // Two rows on column 3: code 13, multi.
    goto_col(3, 1'b1);
    seen_code  = -1;
    seen_multi = -1;
    repeat (7) begin
      step(4'b0110, 1'b1);
      if (key_valid && seen_code < 0) begin
        seen_code  = key_code;
        seen_multi = key_multi;
      end
    end
    check("multi_code", seen_code, 13);
    check("multi_flag", seen_multi, 1);
    repeat (5) step('0, 1'b1);

    // Reset mid-debounce, then reset with an event pending.
    goto_col(1, 1'b1);
    step(4'b0001, 1'b1);
    step(4'b0001, 1'b1);
    do_reset();
    check("post_rst_col", col_drive, 1);
    goto_col(2, 1'b0);
    repeat (6) step(4'b0100, 1'b0);
    check("pending_before_rst", key_valid, 1);
    do_reset();

    // Random presses, bounces, pattern changes and consumer stalls.
    repeat (80) begin
      repeat ($urandom_range(0, 6)) step('0, $urandom_range(0, 3) != 0);
      v = ROWS'($urandom_range(1, (1 << ROWS) - 1));
      for (int h = $urandom_range(1, 10); h > 0; h--) begin
        if ($urandom_range(0, 11) == 0) v = ROWS'($urandom_range(1, (1 << ROWS) - 1));
        step(v, $urandom_range(0, 3) != 0);
      end
      repeat ($urandom_range(1, 8)) step('0, $urandom_range(0, 3) != 0);
    end
    repeat (10) step('0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
